// File: rtl/ascon_pkg.sv
// ascon_pkg: shared constants and types for the AEAD128 output unloader.
//   BLOCK_BYTES / WORD_BYTES / NWORDS describe the default 128-bit block,
//   32-bit word configuration; ser_state_t is the serializer FSM state;
//   ceil_div is a small elaboration/combinational helper.
package ascon_pkg;

    localparam int unsigned BLOCK_BYTES = 16;
    localparam int unsigned WORD_BYTES  = 4;
    localparam int unsigned NWORDS      = BLOCK_BYTES / WORD_BYTES;

    typedef enum logic {
        IDLE,
        SEND
    } ser_state_t;

    function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
        return (n + d - 1) / d;
    endfunction

endpackage

// File: rtl/keep_mask_gen.sv
// keep_mask_gen: combinational per-word byte-keep mask.
//   cnt   - number of valid bytes in the block
//   index - word index within the block
//   keep  - bit j set iff index*WBYTES + j < cnt
module keep_mask_gen
    import ascon_pkg::*;
#(
    parameter int unsigned WBYTES = WORD_BYTES,
    parameter int unsigned CNT_W  = $clog2(BLOCK_BYTES) + 1,
    parameter int unsigned IDX_W  = $clog2(NWORDS) + 1
) (
    input  logic [CNT_W-1:0]  cnt,
    input  logic [IDX_W-1:0]  index,
    output logic [WBYTES-1:0] keep
);

    always_comb begin
        keep = '0;
        for (int unsigned j = 0; j < WBYTES; j++) begin
            keep[j] = ((32'(index) * WBYTES + j) < 32'(cnt));
        end
    end

endmodule

// File: rtl/block_serializer.sv
// block_serializer: unloads one full-width block (ciphertext, plaintext or
// tag) as a least-significant-first stream of narrow words.
//   clk, rst            - clock, synchronous active-low reset
//   blk_valid/blk_ready - block handshake; blk_data, blk_bytes, blk_last
//                         carry the block, its valid-byte count and the
//                         final-block flag
//   word_valid/word_ready - word handshake; word_data, word_keep, word_last
//                         carry the word, per-byte valid flags and the
//                         final-word marker of a last block
// All outputs are registered.
module block_serializer
    import ascon_pkg::*;
#(
    parameter int unsigned BLOCK_WIDTH = BLOCK_BYTES * 8,
    parameter int unsigned WORD_WIDTH  = WORD_BYTES * 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 blk_valid,
    output logic                                 blk_ready,
    input  logic [BLOCK_WIDTH-1:0]               blk_data,
    input  logic [$clog2(BLOCK_WIDTH/8):0]       blk_bytes,
    input  logic                                 blk_last,
    output logic                                 word_valid,
    input  logic                                 word_ready,
    output logic [WORD_WIDTH-1:0]                word_data,
    output logic [WORD_WIDTH/8-1:0]              word_keep,
    output logic                                 word_last
);

    localparam int unsigned BLK_BYTES = BLOCK_WIDTH / 8;
    localparam int unsigned WRD_BYTES = WORD_WIDTH / 8;
    localparam int unsigned N_WORDS   = BLOCK_WIDTH / WORD_WIDTH;
    localparam int unsigned CNT_W     = $clog2(BLK_BYTES) + 1;
    localparam int unsigned IDX_W     = $clog2(N_WORDS) + 1;

    ser_state_t state;

    logic [BLOCK_WIDTH-1:0] cap_data;
    logic [CNT_W-1:0]       cap_bytes;
    logic                   cap_last;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       last_idx;

    // Incoming block, after clamping and byte zeroing
    logic [CNT_W-1:0]       in_bytes;
    logic [IDX_W-1:0]       in_nwords;
    logic [IDX_W-1:0]       in_last_idx;
    logic [WRD_BYTES-1:0]   in_mask [N_WORDS];
    logic [BLOCK_WIDTH-1:0] in_masked;

    // Next word to present while streaming
    logic [IDX_W-1:0]       nxt_idx;
    logic [WORD_WIDTH-1:0]  nxt_word;
    logic [WRD_BYTES-1:0]   nxt_keep;

    assign in_bytes    = (blk_bytes > CNT_W'(BLK_BYTES)) ? CNT_W'(BLK_BYTES) : blk_bytes;
    assign in_nwords   = IDX_W'(ceil_div(32'(in_bytes), WRD_BYTES));
    // A zero-word block still occupies one slot (empty-message marker)
    assign in_last_idx = (in_nwords == '0) ? '0 : in_nwords - IDX_W'(1);

    // Same mask generator swept over every word zeroes bytes past the count
    for (genvar w = 0; w < N_WORDS; w++) begin : g_sweep
        keep_mask_gen #(
            .WBYTES (WRD_BYTES),
            .CNT_W  (CNT_W),
            .IDX_W  (IDX_W)
        ) u_sweep (
            .cnt   (in_bytes),
            .index (IDX_W'(w)),
            .keep  (in_mask[w])
        );
    end

    always_comb begin
        in_masked = '0;
        for (int unsigned w = 0; w < N_WORDS; w++) begin
            for (int unsigned b = 0; b < WRD_BYTES; b++) begin
                in_masked[w*WORD_WIDTH + b*8 +: 8] =
                    blk_data[w*WORD_WIDTH + b*8 +: 8] & {8{in_mask[w][b]}};
            end
        end
    end

    assign nxt_idx = idx + IDX_W'(1);

    always_comb begin
        nxt_word = '0;
        for (int unsigned w = 0; w < N_WORDS; w++) begin
            if (nxt_idx == IDX_W'(w)) begin
                nxt_word = cap_data[w*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    keep_mask_gen #(
        .WBYTES (WRD_BYTES),
        .CNT_W  (CNT_W),
        .IDX_W  (IDX_W)
    ) u_next_keep (
        .cnt   (cap_bytes),
        .index (nxt_idx),
        .keep  (nxt_keep)
    );

    // Output registers are loaded one word ahead: word 0 at acceptance,
    // word k+1 on the handshake of word k, so outputs stay registered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            blk_ready  <= 1'b0;
            word_valid <= 1'b0;
            word_data  <= '0;
            word_keep  <= '0;
            word_last  <= 1'b0;
            idx        <= '0;
            last_idx   <= '0;
            cap_data   <= '0;
            cap_bytes  <= '0;
            cap_last   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    blk_ready <= 1'b1;
                    if (blk_valid && blk_ready) begin
                        if (in_nwords != '0 || blk_last) begin
                            state      <= SEND;
                            blk_ready  <= 1'b0;
                            word_valid <= 1'b1;
                            idx        <= '0;
                            last_idx   <= in_last_idx;
                            cap_data   <= in_masked;
                            cap_bytes  <= in_bytes;
                            cap_last   <= blk_last;
                            word_data  <= in_masked[WORD_WIDTH-1:0];
                            word_keep  <= in_mask[0];
                            word_last  <= blk_last && (in_last_idx == '0);
                        end
                    end
                end
                SEND: begin
                    if (word_ready) begin
                        if (idx == last_idx) begin
                            state      <= IDLE;
                            blk_ready  <= 1'b1;
                            word_valid <= 1'b0;
                            word_data  <= '0;
                            word_keep  <= '0;
                            word_last  <= 1'b0;
                        end else begin
                            idx       <= nxt_idx;
                            word_data <= nxt_word;
                            word_keep <= nxt_keep;
                            word_last <= cap_last && (nxt_idx == last_idx);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
